// File: rtl/nios_core_rst_seq.sv
// -----------------------------------------------------------------------------
// nios_core_rst_seq
//
// Reset sequencer for the system PLL. Pulses the PLL reset, waits for the
// (asynchronous) lock indication to settle, then releases the peripheral
// reset followed by the CPU reset. Lock loss or a software request re-enters
// the sequence; a lock timeout re-pulses the PLL reset.
//
// Parameters
//   PLL_RST_CYCLES : cycles pll_rst is held high per PLL reset attempt (>=2)
//   LOCK_TIMEOUT   : cycles to wait for lock before re-resetting the PLL
//   STABLE_CYCLES  : cycles lock must stay high before any reset is released
//   STAGE_DELAY    : cycles between periph_rst release and cpu_rst release
//
// Ports
//   clk           in  : board reference clock (also feeds the PLL)
//   rst           in  : synchronous, active-high block reset
//   pll_locked    in  : PLL lock status, asynchronous to clk
//   sw_rst_req    in  : single-cycle software reset request (clk domain)
//   pll_rst       out : PLL reset, active high
//   periph_rst    out : peripheral/interconnect reset, active high
//   cpu_rst       out : CPU reset, active high
//   sys_ready     out : high only while in RUN
//   lock_loss_cnt out : lock losses after release, saturates at 255
//   timeout_cnt   out : lock timeouts, saturates at 255
//   state         out : current state code (debug)
// -----------------------------------------------------------------------------
module nios_core_rst_seq #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGE_DELAY    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sw_rst_req,
    output logic       pll_rst,
    output logic       periph_rst,
    output logic       cpu_rst,
    output logic       sys_ready,
    output logic [7:0] lock_loss_cnt,
    output logic [7:0] timeout_cnt,
    output logic [2:0] state
);

    // Counter only ever has to reach (largest parameter - 1), so $clog2 of
    // the largest parameter is enough bits.
    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD = (STABLE_CYCLES > STAGE_DELAY) ? STABLE_CYCLES : STAGE_DELAY;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = (MAX_P > 2) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STAGE_LAST   = CW'(STAGE_DELAY - 1);

    typedef enum logic [2:0] {
        ST_PLL_RST    = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE     = 3'd2,
        ST_REL_PERIPH = 3'd3,
        ST_RUN        = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sync_q;
    logic            locked_s;
    logic            inc_timeout, inc_loss;
    logic            pll_rst_d, periph_rst_d, cpu_rst_d, sys_ready_d;
    logic [7:0]      loss_cnt_q, to_cnt_q;

    // ---------------------------------------------------------------------
    // Lock synchronizer. This is the only place pll_locked is sampled.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign locked_s = sync_q[1];

    // ---------------------------------------------------------------------
    // Next-state logic. Lock loss is tested before the software request and
    // before the dwell-counter expiry so it always wins.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        inc_timeout = 1'b0;
        inc_loss    = 1'b0;

        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PLL_RST_LAST) state_d = ST_WAIT_LOCK;
            end

            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_PLL_RST;
                    inc_timeout = 1'b1;
                end
            end

            ST_STABLE: begin
                // Chatter before release is not counted as a lock loss.
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_REL_PERIPH;
                end
            end

            ST_REL_PERIPH: begin
                if (!locked_s) begin
                    state_d  = ST_WAIT_LOCK;
                    inc_loss = 1'b1;
                end else if (sw_rst_req) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == STAGE_LAST) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!locked_s) begin
                    state_d  = ST_WAIT_LOCK;
                    inc_loss = 1'b1;
                end else if (sw_rst_req) begin
                    state_d = ST_STABLE;
                end
            end

            // Codes 5-7 are unreachable in normal operation; recover via a
            // fresh PLL reset.
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Output decode from the *next* state so the registered outputs change
    // on the same edge as the state register.
    // ---------------------------------------------------------------------
    always_comb begin
        pll_rst_d    = 1'b0;
        periph_rst_d = 1'b1;
        cpu_rst_d    = 1'b1;
        sys_ready_d  = 1'b0;

        case (state_d)
            ST_PLL_RST: begin
                pll_rst_d = 1'b1;
            end
            ST_REL_PERIPH: begin
                periph_rst_d = 1'b0;
            end
            ST_RUN: begin
                periph_rst_d = 1'b0;
                cpu_rst_d    = 1'b0;
                sys_ready_d  = 1'b1;
            end
            default: begin
                pll_rst_d    = 1'b0;
            end
        endcase
    end

    // Dwell counter: cleared on every state change, counts while resident.
    // In RUN it free-runs; nothing looks at it there.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // ---------------------------------------------------------------------
    // State, counter and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_PLL_RST;
            cnt_q      <= '0;
            pll_rst    <= 1'b1;
            periph_rst <= 1'b1;
            cpu_rst    <= 1'b1;
            sys_ready  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pll_rst    <= pll_rst_d;
            periph_rst <= periph_rst_d;
            cpu_rst    <= cpu_rst_d;
            sys_ready  <= sys_ready_d;
        end
    end

    // Event counters saturate at 255 so a long-failing board still reads
    // "many" rather than wrapping back to a small number.
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_cnt_q <= 8'd0;
            to_cnt_q   <= 8'd0;
        end else begin
            if (inc_loss && (loss_cnt_q != 8'hFF)) begin
                loss_cnt_q <= loss_cnt_q + 8'd1;
            end
            if (inc_timeout && (to_cnt_q != 8'hFF)) begin
                to_cnt_q <= to_cnt_q + 8'd1;
            end
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
    assign timeout_cnt   = to_cnt_q;
    assign state         = state_q;

endmodule

// File: tb/tb_nios_core_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_nios_core_rst_seq
//
// Directed bench for nios_core_rst_seq with small timing parameters.
// Expected values go into a scoreboard queue when the stimulus is applied and
// are popped and compared when the DUT output is observed. Inputs are driven
// and outputs sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_nios_core_rst_seq;

    localparam int P_RST = 4;
    localparam int P_TO  = 20;
    localparam int P_STB = 8;
    localparam int P_STG = 4;

    localparam int S_STATE = 0;
    localparam int S_PLL   = 1;
    localparam int S_PER   = 2;
    localparam int S_CPU   = 3;
    localparam int S_RDY   = 4;
    localparam int S_LOSS  = 5;
    localparam int S_TO    = 6;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       sw_rst_req;
    logic       pll_rst;
    logic       periph_rst;
    logic       cpu_rst;
    logic       sys_ready;
    logic [7:0] lock_loss_cnt;
    logic [7:0] timeout_cnt;
    logic [2:0] state;

    nios_core_rst_seq #(
        .PLL_RST_CYCLES (P_RST),
        .LOCK_TIMEOUT   (P_TO),
        .STABLE_CYCLES  (P_STB),
        .STAGE_DELAY    (P_STG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .sw_rst_req    (sw_rst_req),
        .pll_rst       (pll_rst),
        .periph_rst    (periph_rst),
        .cpu_rst       (cpu_rst),
        .sys_ready     (sys_ready),
        .lock_loss_cnt (lock_loss_cnt),
        .timeout_cnt   (timeout_cnt),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0d, nothing expected", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0d, expected %0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        push(tag, exp);
        pop_check(obs);
    endtask

    function automatic logic [31:0] sig(input int which);
        case (which)
            S_STATE: return 32'(state);
            S_PLL:   return 32'(pll_rst);
            S_PER:   return 32'(periph_rst);
            S_CPU:   return 32'(cpu_rst);
            S_RDY:   return 32'(sys_ready);
            S_LOSS:  return 32'(lock_loss_cnt);
            S_TO:    return 32'(timeout_cnt);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // One clock: DUT edge, then back to the sampling/driving point.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count rising edges until a signal reaches a value; bounded by budget.
    task automatic wait_for(input int which, input logic [31:0] val,
                            input int budget, output int n);
        n = 0;
        while (sig(which) !== val && n < budget) begin
            step();
            n++;
        end
    endtask

    // Hard stop if something unbounded slips through.
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: observed no end of test, expected end within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, n1, n2;
        rst        = 1'b1;
        pll_locked = 1'b0;
        sw_rst_req = 1'b0;
        @(negedge clk);
        repeat (3) step();

        // ---- Reset values ----
        chk("rst_state",      sig(S_STATE), 0);
        chk("rst_pll_rst",    sig(S_PLL),   1);
        chk("rst_periph_rst", sig(S_PER),   1);
        chk("rst_cpu_rst",    sig(S_CPU),   1);
        chk("rst_sys_ready",  sig(S_RDY),   0);
        chk("rst_loss_cnt",   sig(S_LOSS),  0);
        chk("rst_to_cnt",     sig(S_TO),    0);

        // ---- Power-up ----
        rst = 1'b0;
        push("pll_rst_width", P_RST);
        wait_for(S_PLL, 0, 20, n);
        pop_check(n);
        chk("wait_lock_entry", sig(S_STATE), 1);
        repeat (6) step();                 // lock arrives 10 cycles after release
        pll_locked = 1'b1;
        // Edge k samples lock; periph released at k+2+STABLE, i.e. the
        // (STABLE+3)th rising edge counting k itself.
        push("periph_rel_lat", P_STB + 3);
        wait_for(S_PER, 0, 100, n);
        pop_check(n);
        chk("rel_cpu_held",  sig(S_CPU),   1);
        chk("rel_state",     sig(S_STATE), 3);
        push("cpu_rel_lat", P_STG);
        wait_for(S_CPU, 0, 100, n);
        pop_check(n);
        chk("run_sys_ready", sig(S_RDY),   1);
        chk("run_state",     sig(S_STATE), 4);

        // ---- Lock loss in RUN ----
        pll_locked = 1'b0;
        push("loss_assert_lat", 3);        // edges k, k+1, k+2
        wait_for(S_PER, 1, 20, n);
        pop_check(n);
        chk("loss_state",     sig(S_STATE), 1);
        chk("loss_cpu_rst",   sig(S_CPU),   1);
        chk("loss_sys_ready", sig(S_RDY),   0);
        chk("loss_pll_rst",   sig(S_PLL),   0);
        chk("loss_cnt_1",     sig(S_LOSS),  1);
        pll_locked = 1'b1;
        push("relock_ready_lat", P_STB + P_STG + 3);
        wait_for(S_RDY, 1, 100, n);
        pop_check(n);

        // ---- Software reset in RUN ----
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        chk("sw_state",      sig(S_STATE), 2);
        chk("sw_periph_rst", sig(S_PER),   1);
        chk("sw_cpu_rst",    sig(S_CPU),   1);
        chk("sw_sys_ready",  sig(S_RDY),   0);
        push("sw_rerelease_lat", P_STB + P_STG);
        wait_for(S_RDY, 1, 100, n);
        pop_check(n);
        chk("sw_loss_cnt", sig(S_LOSS), 1);
        chk("sw_to_cnt",   sig(S_TO),   0);

        // ---- Software request on the same edge as locked_s falling ----
        pll_locked = 1'b0;
        step();
        step();
        sw_rst_req = 1'b1;                 // seen on edge k+2 with locked_s=0
        step();
        sw_rst_req = 1'b0;
        chk("collide_state",    sig(S_STATE), 1);
        chk("collide_loss_cnt", sig(S_LOSS),  2);
        chk("collide_periph",   sig(S_PER),   1);

        // ---- Mid-sequence rst during REL_PERIPH ----
        pll_locked = 1'b1;
        wait_for(S_STATE, 3, 100, n);
        chk("reach_rel", sig(S_STATE), 3);
        rst = 1'b1;
        step();
        chk("midrst_state",    sig(S_STATE), 0);
        chk("midrst_pll_rst",  sig(S_PLL),   1);
        chk("midrst_periph",   sig(S_PER),   1);
        chk("midrst_cpu",      sig(S_CPU),   1);
        chk("midrst_loss_cnt", sig(S_LOSS),  0);
        chk("midrst_to_cnt",   sig(S_TO),    0);
        rst = 1'b0;

        // ---- Lock chatter in STABLE ----
        wait_for(S_STATE, 2, 50, n);
        chk("chatter_stable", sig(S_STATE), 2);
        repeat (5) step();                 // dwell counter now 5
        pll_locked = 1'b0;
        step();
        step();
        pll_locked = 1'b1;
        step();
        chk("chatter_wait",   sig(S_STATE), 1);
        chk("chatter_periph", sig(S_PER),   1);
        // One more WAIT_LOCK cycle, then a full stable window.
        push("chatter_window", P_STB + 2);
        wait_for(S_STATE, 3, 100, n);
        pop_check(n);
        chk("chatter_loss_cnt", sig(S_LOSS), 0);

        // ---- Lock timeout and saturation ----
        rst        = 1'b1;
        pll_locked = 1'b0;
        step();
        step();
        rst = 1'b0;
        wait_for(S_PLL, 0, 20, n);
        push("first_timeout_gap", P_TO);
        wait_for(S_PLL, 1, 50, n);
        pop_check(n);
        chk("timeout_1", sig(S_TO), 1);
        for (int i = 0; i < 3; i++) begin
            wait_for(S_PLL, 0, 50, n1);
            wait_for(S_PLL, 1, 50, n2);
            chk("pll_rst_period", n1 + n2, P_RST + P_TO);
            chk("timeout_inc",    sig(S_TO), i + 2);
        end
        repeat (300 * (P_RST + P_TO)) step();
        chk("timeout_sat",      sig(S_TO),   255);
        chk("timeout_periph",   sig(S_PER),  1);
        chk("timeout_loss_cnt", sig(S_LOSS), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
